sync_fifo_rd_streamer: RTL and testbench

//  Read-side consumer for sync_fifo: drains exactly LEN words per burst via the FIFO's RD_EN/DATA_OUT/EMPTY

---
 rtl/sync_fifo_rd_streamer.sv | 135 +++++++++++++
 tb/tb_sync_fifo_rd_streamer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_rd_streamer
// Description : Drains LEN words per burst from a sync FIFO read port and
//               re-emits them on a valid/ready stream via a 2-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_rd_streamer #(
    parameter int FIFO_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    input  logic [FIFO_WIDTH-1:0] data_out_i,
    input  logic                  empty_i,
    output logic [FIFO_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [LEN_WIDTH-1:0]  xfer_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  xfer_q, xfer_d;
    logic                  inflight_q, inflight_d;
    logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
    logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  w_deq;
    logic [2:0]            w_occ;
    logic                  w_rd_en;

    // Credit check: buffered + in-flight words, net of this cycle's dequeue.
    assign w_deq   = (cnt_q != 2'd0) & m_ready_i;
    assign w_occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, w_deq};
    assign w_rd_en = (state_q == S_RUN) & ~empty_i & (issued_q < len_q) & (w_occ < 3'd2);

    assign rd_en_o    = w_rd_en;
    assign m_valid_o  = (cnt_q != 2'd0);
    assign m_data_o   = buf0_q;
    assign busy_o     = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign xfer_cnt_o = xfer_q;

    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        cnt_d      = cnt_q;
        inflight_d = w_rd_en;
        if (w_deq) begin
            buf0_d = buf1_q;
            cnt_d  = cnt_d - 2'd1;
        end
        // Read data from last cycle's issue lands behind whatever remains.
        if (inflight_q) begin
            if (cnt_d == 2'd0) begin
                buf0_d = data_out_i;
            end else begin
                buf1_d = data_out_i;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        xfer_d   = xfer_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d    = len_i;
                    issued_d = '0;
                    xfer_d   = '0;
                    state_d  = (len_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_rd_en) begin
                    issued_d = issued_q + LEN_WIDTH'(1);
                end
                if (w_deq && (xfer_q < len_q)) begin
                    xfer_d = xfer_q + LEN_WIDTH'(1);
                    if (xfer_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            xfer_q     <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            xfer_q     <= xfer_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_rd_streamer
// Description : Directed self-checking bench with a behavioural FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_rd_streamer;

    localparam int W  = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          busy, done, rd_en, m_valid, m_ready;
    logic [W-1:0]  data_out = '0;
    logic [W-1:0]  m_data;
    logic [LW-1:0] xfer_cnt;
    logic          empty;
    logic          force_empty;

    logic [W-1:0]  mem [0:63];
    int            rd_ptr = 0;
    int            wr_ptr = 0;
    logic          flush_req = 1'b0;
    logic          clr_mon = 1'b0;
    int            cyc = 0;

    int            n_rd, first_rd, last_rd, rx_cnt, n_done, max_out;
    logic          rd_while_empty, saw_valid;
    logic [W-1:0]  rx [0:15];
    int            rx_cyc [0:15];

    int            tests = 0;
    int            fails = 0;

    sync_fifo_rd_streamer #(.FIFO_WIDTH(W), .LEN_WIDTH(LW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .rd_en_o    (rd_en),
        .data_out_i (data_out),
        .empty_i    (empty),
        .m_data_o   (m_data),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .xfer_cnt_o (xfer_cnt)
    );

    always #5 clk = ~clk;

    assign empty = (rd_ptr == wr_ptr) || force_empty;

    // FIFO model: registered read data, one cycle after RD_EN.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (rd_en && !empty) begin
            data_out <= mem[rd_ptr % 64];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (clr_mon) begin
            n_rd = 0; first_rd = -1; last_rd = -1; rx_cnt = 0; n_done = 0;
            max_out = 0; rd_while_empty = 1'b0; saw_valid = 1'b0;
        end else if (rst_n) begin
            if (rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (empty) rd_while_empty = 1'b1;
            end
            if (m_valid) saw_valid = 1'b1;
            if (m_valid && m_ready) begin
                if (rx_cnt < 16) begin
                    rx[rx_cnt]     = m_data;
                    rx_cyc[rx_cnt] = cyc;
                end
                rx_cnt++;
            end
            if (done) n_done++;
            if (n_rd - rx_cnt > max_out) max_out = n_rd - rx_cnt;
        end
    end

    task automatic clear_mon();
        clr_mon = 1'b1;
        @(negedge clk);
        #1 clr_mon = 1'b0;
    endtask

    task automatic preload(input logic [W-1:0] base, input int n);
        @(posedge clk); #1 flush_req = 1'b1;
        @(posedge clk); #1 flush_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 64] = base + W'(i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic start_burst(input logic [LW-1:0] l);
        @(posedge clk); #1 start = 1'b1; len = l;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; m_ready = 1'b0; force_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, rd_en, m_valid} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, rd_en, m_valid});
        end
        tests++;
        if (m_data !== 8'h00 || xfer_cnt !== 8'h00) begin
            fails++; $display("FAIL reset_data got m_data=%h xfer=%0d exp 00/0", m_data, xfer_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        clear_mon();
        @(posedge clk); #1;
        tests++;
        if ({busy, done, rd_en, m_valid} !== 4'b0000) begin
            fails++; $display("FAIL post_reset_idle got=%b exp=0000", {busy, done, rd_en, m_valid});
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [W-1:0] exp [0:3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        clear_mon();
        @(posedge clk); #1 flush_req = 1'b1;
        @(posedge clk); #1 flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin mem[wr_ptr % 64] = exp[i]; wr_ptr = wr_ptr + 1; end
        m_ready = 1'b1;
        start_burst(8'd4);
        wait_done(50, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_done_timeout got=none exp=DONE pulse"); end
        tests++;
        if (n_rd !== 4 || last_rd - first_rd !== 3) begin
            fails++; $display("FAIL basic_rd_en got n=%0d span=%0d exp n=4 span=3", n_rd, last_rd - first_rd);
        end
        tests++;
        if (rx_cnt !== 4) begin fails++; $display("FAIL basic_count got=%0d exp=4", rx_cnt); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rx[i] !== exp[i]) begin fails++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, rx[i], exp[i]); end
        end
        tests++;
        if (rx_cyc[3] - rx_cyc[0] !== 3 || rx_cyc[0] - first_rd !== 2) begin
            fails++; $display("FAIL basic_timing got span=%0d lat=%0d exp span=3 lat=2", rx_cyc[3] - rx_cyc[0], rx_cyc[0] - first_rd);
        end
        tests++;
        if (n_done !== 1 || xfer_cnt !== 8'd4 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_end got done=%0d xfer=%0d busy=%b exp 1/4/0", n_done, xfer_cnt, busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok, seen, unstable;
        logic [W-1:0] hold;
        clear_mon();
        preload(8'hA0, 6);
        m_ready = 1'b0;
        start_burst(8'd6);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL bp_valid_timeout got=none exp=M_VALID"); end
        hold = m_data;
        unstable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (m_data !== hold || m_valid !== 1'b1) unstable = 1'b1;
        end
        tests++;
        if (hold !== 8'hA0 || unstable) begin
            fails++; $display("FAIL bp_hold got=%h unstable=%b exp=a0 stable", hold, unstable);
        end
        @(posedge clk); #1 m_ready = 1'b1;
        wait_done(60, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_done_timeout got=none exp=DONE pulse"); end
        tests++;
        if (max_out !== 2) begin fails++; $display("FAIL bp_outstanding got=%0d exp=2", max_out); end
        tests++;
        if (rx_cnt !== 6) begin fails++; $display("FAIL bp_count got=%0d exp=6", rx_cnt); end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (rx[i] !== 8'hA0 + W'(i)) begin fails++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, rx[i], 8'hA0 + W'(i)); end
        end
    endtask

    task automatic test_empty_toggle();
        bit ok;
        logic [15:0] pat;
        pat = 16'b0110_1100_1011_0010;
        clear_mon();
        preload(8'h30, 8);
        m_ready = 1'b1;
        start_burst(8'd8);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1 force_empty = pat[i % 16];
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        force_empty = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (!ok) begin fails++; $display("FAIL empty_done_timeout got=none exp=DONE pulse"); end
        tests++;
        if (rd_while_empty !== 1'b0) begin fails++; $display("FAIL rd_while_empty got=1 exp=0"); end
        tests++;
        if (rx_cnt !== 8 || xfer_cnt !== 8'd8) begin
            fails++; $display("FAIL empty_count got rx=%0d xfer=%0d exp 8/8", rx_cnt, xfer_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (rx[i] !== 8'h30 + W'(i)) begin fails++; $display("FAIL empty_data[%0d] got=%h exp=%h", i, rx[i], 8'h30 + W'(i)); end
        end
    endtask

    task automatic test_len_zero();
        clear_mon();
        preload(8'hC0, 2);
        @(posedge clk); #1 start = 1'b1; len = 8'd0;
        @(posedge clk); #1 start = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || xfer_cnt !== 8'd0) begin
            fails++; $display("FAIL len0_pulse got done=%b busy=%b xfer=%0d exp 1/0/0", done, busy, xfer_cnt);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL len0_pulse_width got done=%b exp=0", done); end
        repeat (5) @(negedge clk);
        tests++;
        if (n_rd !== 0 || saw_valid !== 1'b0 || n_done !== 1) begin
            fails++; $display("FAIL len0_quiet got rd=%0d valid=%b done=%0d exp 0/0/1", n_rd, saw_valid, n_done);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_mon();
        preload(8'h50, 6);
        m_ready = 1'b1;
        start_burst(8'd3);
        @(posedge clk); #1 start = 1'b1; len = 8'd5;
        @(posedge clk); #1 start = 1'b0;
        wait_done(50, ok);
        repeat (4) @(negedge clk);
        tests++;
        if (!ok) begin fails++; $display("FAIL ign_done_timeout got=none exp=DONE pulse"); end
        tests++;
        if (rx_cnt !== 3 || n_rd !== 3 || xfer_cnt !== 8'd3 || n_done !== 1) begin
            fails++; $display("FAIL ign_len got rx=%0d rd=%0d xfer=%0d done=%0d exp 3/3/3/1", rx_cnt, n_rd, xfer_cnt, n_done);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rx[i] !== 8'h50 + W'(i)) begin fails++; $display("FAIL ign_data[%0d] got=%h exp=%h", i, rx[i], 8'h50 + W'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, got2;
        clear_mon();
        preload(8'h60, 5);
        m_ready = 1'b1;
        start_burst(8'd5);
        got2 = 1'b0;
        for (int i = 0; i < 30 && !got2; i++) begin
            @(negedge clk);
            if (rx_cnt >= 2) got2 = 1'b1;
        end
        tests++;
        if (!got2) begin fails++; $display("FAIL mid_progress_timeout got rx=%0d exp>=2", rx_cnt); end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, rd_en, m_valid} !== 4'b0000 || m_data !== 8'h00 || xfer_cnt !== 8'h00) begin
            fails++; $display("FAIL mid_async_reset got flags=%b data=%h xfer=%0d exp 0000/00/0", {busy, done, rd_en, m_valid}, m_data, xfer_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (n_done !== 0 || rx_cnt >= 5) begin
            fails++; $display("FAIL mid_no_done got done=%0d rx=%0d exp done=0 rx<5", n_done, rx_cnt);
        end
        clear_mon();
        preload(8'h70, 3);
        start_burst(8'd3);
        wait_done(50, ok);
        tests++;
        if (!ok || rx_cnt !== 3 || xfer_cnt !== 8'd3 || n_done !== 1) begin
            fails++; $display("FAIL mid_rerun got ok=%b rx=%0d xfer=%0d done=%0d exp 1/3/3/1", ok, rx_cnt, xfer_cnt, n_done);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rx[i] !== 8'h70 + W'(i)) begin fails++; $display("FAIL mid_data[%0d] got=%h exp=%h", i, rx[i], 8'h70 + W'(i)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_toggle();
        test_len_zero();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
